// File: rtl/rst_seq_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : rst_seq_pkg                                                |
// | Description : Shared types and helpers for the rst_seq_gen reset         |
// |               sequencer: FSM state encoding, counter width helper and    |
// |               the upper bound on the number of reset domains.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package rst_seq_pkg;

   // Largest supported number of reset outputs.
   localparam int MAX_DOM = 16;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   // Width of the shared stretch/gap counter. The counter only ever has to
   // reach max(stretch, gap) - 1, so this leaves one value of headroom.
   function automatic int cnt_w(input int stretch, input int gap);
      int m;
      m = (stretch > gap) ? stretch : gap;
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

endpackage : rst_seq_pkg
`default_nettype wire

// File: rtl/rst_seq_gen_bufg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rst_seq_bufg                                               |
// | Description : Global-buffer cell for one reset output. Behaviourally a   |
// |               straight wire; the attribute asks the implementation flow  |
// |               to place a BUFG on this net.                               |
// | Ports       : i_d  in   flop output to be buffered                       |
// |               o_q  out  buffered reset                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rst_seq_bufg (
   input  logic i_d,
   (* clock_buffer_type = "BUFG" *)
   output logic o_q
);

   assign o_q = i_d;

endmodule : rst_seq_bufg
`default_nettype wire

// File: rtl/rst_seq_gen_sync_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rst_sync_chain                                             |
// | Description : Asynchronous-assert, synchronous-deassert reset chain.     |
// |               A 1 is shifted in on every clock edge while RST is low; the |
// |               internal reset is the inverse of the last stage.           |
// | Ports       : CLK        in   clock                                      |
// |               RST        in   async active-high reset                    |
// |               o_rst_int  out  synchronised internal reset, active-high   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rst_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   output logic o_rst_int
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], 1'b1};
      end
   end

   assign o_rst_int = ~r_chain[STAGES-1];

endmodule : rst_sync_chain
`default_nettype wire

// File: rtl/rst_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rst_seq_gen                                                |
// | Description : Multi-domain reset sequencer. All outputs assert           |
// |               asynchronously on RST; after synchronised deassertion and  |
// |               a stretch period they release one at a time, bit 0 first,  |
// |               spaced by GAP cycles. SOFT_RST re-runs the sequence.       |
// | Ports       : CLK       in   clock                                       |
// |               RST       in   async active-high reset                     |
// |               SOFT_RST  in   synchronous soft-reset request              |
// |               RST_OUT   out  per-domain resets, active-high [N_DOM]      |
// |               READY     out  all domains released                        |
// |               BUSY      out  release sequence in progress                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rst_seq_gen
   import rst_seq_pkg::*;
#(
   parameter int N_DOM       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 16,
   parameter int GAP         = 4,
   parameter int USE_BUFG    = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SOFT_RST,
   output logic [N_DOM-1:0] RST_OUT,
   output logic             READY,
   output logic             BUSY
);

   localparam int c_CW = cnt_w(STRETCH, GAP);
   localparam int c_IW = $clog2(MAX_DOM + 1);

   localparam logic [c_CW-1:0] c_STRETCH_M1 = c_CW'(STRETCH - 1);
   localparam logic [c_CW-1:0] c_GAP_M1     = c_CW'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [c_IW-1:0] c_LAST_IDX   = c_IW'(N_DOM - 1);
   // With a single domain or no gap, everything releases on the stretch edge.
   localparam bit              c_ALL_AT_ONCE = (N_DOM == 1) || (GAP == 0);

   logic             w_rst_int;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [c_CW-1:0]  r_cnt;
   logic [c_CW-1:0]  w_cnt_nxt;
   logic [c_IW-1:0]  r_idx;
   logic [c_IW-1:0]  w_idx_nxt;
   logic [N_DOM-1:0] r_rst_out;
   logic [N_DOM-1:0] w_rst_out_nxt;
   logic             r_ready;
   logic             w_ready_nxt;
   logic             r_busy;
   logic             w_busy_nxt;

   rst_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK       (CLK),
      .RST       (RST),
      .o_rst_int (w_rst_int)
   );

   // State, counter, index and output flops. Every RST_OUT bit is its own
   // flop with async set so it asserts without a clock and never glitches.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= ST_HOLD;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_rst_out <= '1;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_rst_out <= w_rst_out_nxt;
         r_ready   <= w_ready_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_rst_out_nxt = r_rst_out;

      unique case (r_state)
         ST_HOLD: begin
            // SOFT_RST is deliberately ignored until the sync chain releases.
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (!w_rst_int) begin
               w_state_nxt = ST_STRETCH;
            end
         end

         ST_STRETCH: begin
            if (SOFT_RST) begin
               w_rst_out_nxt = '1;
               w_cnt_nxt     = '0;
               w_idx_nxt     = '0;
            end else if (r_cnt == c_STRETCH_M1) begin
               w_cnt_nxt = '0;
               if (c_ALL_AT_ONCE) begin
                  w_rst_out_nxt = '0;
                  w_state_nxt   = ST_RUN;
               end else begin
                  w_rst_out_nxt[0] = 1'b0;
                  w_idx_nxt        = c_IW'(1);
                  w_state_nxt      = ST_RELEASE;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_CW'(1);
            end
         end

         ST_RELEASE: begin
            // A soft reset on a release edge wins: no bit is released.
            if (SOFT_RST) begin
               w_rst_out_nxt = '1;
               w_cnt_nxt     = '0;
               w_idx_nxt     = '0;
               w_state_nxt   = ST_STRETCH;
            end else if (r_cnt == c_GAP_M1) begin
               for (int i = 0; i < N_DOM; i++) begin
                  if (i == int'(r_idx)) begin
                     w_rst_out_nxt[i] = 1'b0;
                  end
               end
               w_cnt_nxt = '0;
               w_idx_nxt = r_idx + c_IW'(1);
               if (r_idx == c_LAST_IDX) begin
                  w_state_nxt = ST_RUN;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_CW'(1);
            end
         end

         ST_RUN: begin
            if (SOFT_RST) begin
               w_rst_out_nxt = '1;
               w_cnt_nxt     = '0;
               w_idx_nxt     = '0;
               w_state_nxt   = ST_STRETCH;
            end
         end

         default: begin
            w_state_nxt = ST_HOLD;
         end
      endcase

      // Status flags are registered from the next state so they change on
      // the same edge as the outputs they describe.
      w_ready_nxt = (w_state_nxt == ST_RUN);
      w_busy_nxt  = (w_state_nxt == ST_STRETCH) || (w_state_nxt == ST_RELEASE);
   end

   assign READY = r_ready;
   assign BUSY  = r_busy;

   for (genvar g = 0; g < N_DOM; g++) begin : g_dom
      if (USE_BUFG != 0) begin : g_bufg
         rst_seq_bufg u_bufg (
            .i_d (r_rst_out[g]),
            .o_q (RST_OUT[g])
         );
      end else begin : g_direct
         assign RST_OUT[g] = r_rst_out[g];
      end
   end

endmodule : rst_seq_gen
`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rst_seq_gen                                             |
// | Description : Directed self-checking bench for rst_seq_gen. A default    |
// |               instance and a GAP=0 / N_DOM=4 instance share the stimulus;|
// |               edge numbers count rising edges after RST is released.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rst_seq_gen;

   logic       CLK;
   logic       RST;
   logic       SOFT_RST;
   logic [2:0] rst_out;
   logic       ready;
   logic       busy;
   logic [3:0] rst_out0;
   logic       ready0;
   logic       busy0;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   rst_seq_gen u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .SOFT_RST (SOFT_RST),
      .RST_OUT  (rst_out),
      .READY    (ready),
      .BUSY     (busy)
   );

   rst_seq_gen #(
      .N_DOM (4),
      .GAP   (0)
   ) u_dut_gap0 (
      .CLK      (CLK),
      .RST      (RST),
      .SOFT_RST (SOFT_RST),
      .RST_OUT  (rst_out0),
      .READY    (ready0),
      .BUSY     (busy0)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1 ns after it.
   task automatic tick();
      @(posedge CLK);
      #1;
      edge_n++;
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) tick();
   endtask

   // Drop RST 2 ns after a rising edge so the next edge is edge 1.
   task automatic release_rst();
      @(posedge CLK);
      #2;
      RST    = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      RST      = 1'b1;
      SOFT_RST = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_rst_out", 32'(rst_out), 32'h7);
      chk("reset_ready", 32'(ready), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_rst_out_gap0", 32'(rst_out0), 32'hF);

      // ---- Power-on sequence ----
      release_rst();
      run_to(2);
      chk("hold_busy_e2", 32'(busy), 32'h0);
      run_to(3);
      chk("stretch_busy_e3", 32'(busy), 32'h1);
      chk("stretch_out_e3", 32'(rst_out), 32'h7);
      run_to(18);
      chk("pre_rel_out_e18", 32'(rst_out), 32'h7);
      chk("gap0_out_e18", 32'(rst_out0), 32'hF);
      chk("gap0_ready_e18", 32'(ready0), 32'h0);
      run_to(19);
      chk("rel0_out_e19", 32'(rst_out), 32'h6);
      chk("rel0_ready_e19", 32'(ready), 32'h0);
      chk("gap0_out_e19", 32'(rst_out0), 32'h0);
      chk("gap0_ready_e19", 32'(ready0), 32'h1);
      chk("gap0_busy_e19", 32'(busy0), 32'h0);
      run_to(22);
      chk("gap_out_e22", 32'(rst_out), 32'h6);
      run_to(23);
      chk("rel1_out_e23", 32'(rst_out), 32'h4);
      run_to(26);
      chk("gap_out_e26", 32'(rst_out), 32'h4);
      chk("busy_e26", 32'(busy), 32'h1);
      chk("ready_e26", 32'(ready), 32'h0);
      run_to(27);
      chk("rel2_out_e27", 32'(rst_out), 32'h0);
      chk("ready_e27", 32'(ready), 32'h1);
      chk("busy_e27", 32'(busy), 32'h0);

      // ---- One-cycle soft reset at edge 100 ----
      run_to(99);
      SOFT_RST = 1'b1;
      run_to(100);
      SOFT_RST = 1'b0;
      chk("soft_out_e100", 32'(rst_out), 32'h7);
      chk("soft_ready_e100", 32'(ready), 32'h0);
      chk("soft_busy_e100", 32'(busy), 32'h1);
      run_to(115);
      chk("soft_out_e115", 32'(rst_out), 32'h7);
      run_to(116);
      chk("soft_rel0_e116", 32'(rst_out), 32'h6);
      run_to(120);
      chk("soft_rel1_e120", 32'(rst_out), 32'h4);
      run_to(124);
      chk("soft_rel2_e124", 32'(rst_out), 32'h0);
      chk("soft_ready_e124", 32'(ready), 32'h1);

      // ---- Soft reset held for edges 150..159 ----
      run_to(149);
      SOFT_RST = 1'b1;
      run_to(159);
      chk("held_out_e159", 32'(rst_out), 32'h7);
      SOFT_RST = 1'b0;
      run_to(174);
      chk("held_out_e174", 32'(rst_out), 32'h7);
      run_to(175);
      chk("held_rel0_e175", 32'(rst_out), 32'h6);

      // ---- Soft reset on the edge bit 1 would release (179) ----
      run_to(178);
      SOFT_RST = 1'b1;
      run_to(179);
      SOFT_RST = 1'b0;
      chk("clash_out_e179", 32'(rst_out), 32'h7);
      chk("clash_busy_e179", 32'(busy), 32'h1);
      chk("clash_ready_e179", 32'(ready), 32'h0);
      run_to(194);
      chk("clash_out_e194", 32'(rst_out), 32'h7);
      run_to(195);
      chk("clash_rel0_e195", 32'(rst_out), 32'h6);
      run_to(199);
      chk("clash_rel1_e199", 32'(rst_out), 32'h4);
      run_to(203);
      chk("clash_rel2_e203", 32'(rst_out), 32'h0);
      chk("clash_ready_e203", 32'(ready), 32'h1);

      // ---- RST asserted mid-RELEASE between edges 21 and 22 ----
      RST = 1'b1;
      release_rst();
      run_to(21);
      chk("mid_out_e21", 32'(rst_out), 32'h6);
      #3;
      RST = 1'b1;
      #1;
      chk("async_out", 32'(rst_out), 32'h7);
      chk("async_ready", 32'(ready), 32'h0);
      chk("async_busy", 32'(busy), 32'h0);
      release_rst();
      run_to(18);
      chk("rerun_out_e18", 32'(rst_out), 32'h7);
      run_to(19);
      chk("rerun_rel0_e19", 32'(rst_out), 32'h6);
      run_to(23);
      chk("rerun_rel1_e23", 32'(rst_out), 32'h4);
      run_to(26);
      chk("rerun_ready_e26", 32'(ready), 32'h0);
      run_to(27);
      chk("rerun_rel2_e27", 32'(rst_out), 32'h0);
      chk("rerun_ready_e27", 32'(ready), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rst_seq_gen
`default_nettype wire

// File: doc/rst_seq_gen.md
# rst_seq_gen

Parametrised reset sequencer for the ADC readout firmware; successor to the single-output reset synchroniser. It asserts `N_DOM` reset outputs asynchronously and releases them synchronously to `CLK`. Release follows a programmable stretch, then one output at a time in ascending index order with a programmable gap. Each output can be routed through a global buffer. A synchronous soft-reset request re-runs the sequence without an external `RST`.

## Interface

**Parameters**
- `N_DOM`, default 3: number of reset outputs, 1..16.
- `SYNC_STAGES`, default 2: deassertion synchroniser depth, 2..4.
- `STRETCH`, default 16: cycles all outputs stay asserted after the synchroniser has released, 1..65535.
- `GAP`, default 4: cycles between successive output releases, 0..65535. A value of 0 releases all outputs on the same edge.
- `USE_BUFG`, default 1: 1 routes each `RST_OUT` bit through a BUFG; 0 drives it directly from its flop.

**Ports**
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `SOFT_RST`  in  1  synchronous soft-reset request, sampled on each `CLK` edge, level or pulse.
- `RST_OUT`  out  N_DOM  per-domain reset, active-high; bit 0 is released first.
- `READY`  out  1  high once every `RST_OUT` bit is released.
- `BUSY`  out  1  high while a release sequence is in progress (states `STRETCH` and `RELEASE`).

## Operation

- **Reset values while `RST` = 1 (asynchronous):** `RST_OUT` all ones, `READY` = 0, `BUSY` = 0, synchroniser chain all zeros, state `HOLD`, counter 0, release index 0.
- **Synchroniser:** chain shifts in 1 on each edge. The internal reset `rst_int` = NOT last stage, so `rst_int` falls after `SYNC_STAGES` edges with `RST` low.
- **FSM states:**
  - `HOLD`: go to `STRETCH` when `rst_int` = 0; clear the counter.
  - `STRETCH`: increment the counter each edge. When counter = `STRETCH`−1, go to `RELEASE`, clear `RST_OUT[0]`, set index = 1, clear the counter.
  - `RELEASE`:
    - If `N_DOM` = 1 or `GAP` = 0, all remaining bits clear on the same edge that `RST_OUT[0]` clears, and the FSM goes straight to `RUN`.
    - Otherwise, when counter = `GAP`−1, clear `RST_OUT[index]`, increment index, and clear the counter. After the last bit is cleared, go to `RUN`.
  - `RUN`: `READY` = 1; outputs are static.
- **Soft reset:** `SOFT_RST` sampled high in any state other than `HOLD` does the following on that edge:
  - sets all `RST_OUT` bits to 1;
  - sets `READY` to 0;
  - enters `STRETCH` with the counter cleared.
  
  Holding `SOFT_RST` high keeps restarting `STRETCH`. In `HOLD`, `SOFT_RST` is ignored.
- **Simultaneous events:** `RST` overrides everything. `SOFT_RST` in the same cycle as a release edge wins, so no bit is released that cycle.
- **`RST` mid-sequence:** all outputs re-assert immediately and the full sequence restarts from `HOLD`.
- **Glitch-free outputs:** each `RST_OUT` bit is a dedicated flop with async set. No output is driven through combinational logic before the BUFG.

## Timing

- Edge numbering: edge 1 is the first `CLK` rising edge after `RST` falls with setup met. The real first edge may be ±1 because of metastability.
- `RST_OUT[0]` falls at edge `SYNC_STAGES` + `STRETCH` + 1.
- `RST_OUT[i]` falls `i`·`GAP` edges after `RST_OUT[0]`.
- `READY` rises on the same edge that `RST_OUT[N_DOM-1]` falls. `BUSY` falls on that same edge.
- Soft reset sampled at edge e:
  - `RST_OUT` is all ones after edge e;
  - `RST_OUT[0]` falls at edge e + `STRETCH`;
  - later bits follow the same `GAP` spacing.
- Assertion latency from `RST` rising: combinational through the async set, no clock required.
- Counter width: `$clog2(max(STRETCH, GAP) + 1)`. No wrap-around is possible, because the counter clears on every transition.

## Structure

- Package `rst_seq_pkg`:
  - state enum `HOLD`/`STRETCH`/`RELEASE`/`RUN`, 2-bit;
  - function `cnt_w(stretch, gap)` returning the counter width;
  - constant `MAX_DOM` = 16.
- Sub-module `rst_sync_chain`, parameter `STAGES`: async-assert, sync-deassert chain producing `rst_int`.
- The top level holds the FSM, counter, release index, output flops, and a generate loop for the BUFGs.

## Test plan

- Default parameters, `RST` pulse then released → `RST_OUT[0]` falls at edge 19, `RST_OUT[1]` at edge 23, `RST_OUT[2]` at edge 27; `READY` = 1 at edge 27; `BUSY` high from edge 3 to edge 27.
- In `RUN`, one-cycle `SOFT_RST` at edge 100 → `RST_OUT` = 3'b111 after edge 100; bits fall at edges 116, 120 and 124.
- `RST` asserted between clock edges at edge 21.5 (mid-`RELEASE`) → `RST_OUT` = all ones before edge 22; full 27-edge sequence repeats after release.
- `GAP` = 0, `N_DOM` = 4 → all four bits fall together at edge 19; `READY` = 1 at edge 19.
- `SOFT_RST` held high for edges 50..59 during `RUN` → outputs stay asserted; `RST_OUT[0]` falls at edge 59 + 16 = 75.
- `SOFT_RST` = 1 on the same edge `RST_OUT[1]` would release → no release on that edge; sequence restarts from `STRETCH`.
